// File: rtl/uart_rx_if.sv
// Bundle of the serial-line and received-byte signals between a UART receiver
// and its user. The receiver takes the slave side; whoever drives the line takes master.
interface uart_rx_if #(
  parameter int DW = 8
);
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          Data_Valid;
  logic          par_err;
  logic          stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, Data_Valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, Data_Valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// 8N1 or 8E1/8O1 framing, one-cycle result pulses on the return to IDLE.
module uart_rx #(
  parameter int PRESCALE = 8,
  parameter int DW       = 8
) (
  input logic     CLK,
  input logic     RST,
  uart_rx_if.slave bus
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [EW-1:0] EDGE_VOTE0 = EW'(PRESCALE/2 - 1);
  localparam logic [EW-1:0] EDGE_VOTE1 = EW'(PRESCALE/2);
  localparam logic [EW-1:0] EDGE_EVAL  = EW'(PRESCALE/2 + 1);
  localparam logic [EW-1:0] EDGE_LAST  = EW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DW - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        r_state;
  logic          r_sync1;
  logic          r_rxS;
  logic          r_rxPrev;
  logic [EW-1:0] r_edgeCnt;
  logic [BW-1:0] r_bitCnt;
  logic          r_vote0;
  logic          r_vote1;
  logic [DW-1:0] r_shift;
  logic          r_parEn;
  logic          r_parTyp;
  logic          r_parBad;
  logic [DW-1:0] r_pData;
  logic          r_dataValid;
  logic          r_parErr;
  logic          r_stpErr;

  logic w_maj;
  logic w_startEdge;
  logic w_expPar;

  // The third vote sample is the live synchronised line, so the bit value is ready at EDGE_EVAL.
  assign w_maj       = (r_vote0 & r_vote1) | (r_vote0 & r_rxS) | (r_vote1 & r_rxS);
  assign w_startEdge = r_rxPrev & ~r_rxS;
  assign w_expPar    = (^r_shift) ^ r_parTyp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_sync1     <= 1'b1;
      r_rxS       <= 1'b1;
      r_rxPrev    <= 1'b1;
      r_edgeCnt   <= '0;
      r_bitCnt    <= '0;
      r_vote0     <= 1'b1;
      r_vote1     <= 1'b1;
      r_shift     <= '0;
      r_parEn     <= 1'b0;
      r_parTyp    <= 1'b0;
      r_parBad    <= 1'b0;
      r_pData     <= '0;
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      r_stpErr    <= 1'b0;
    end else begin
      r_sync1     <= bus.RX_IN;
      r_rxS       <= r_sync1;
      r_rxPrev    <= r_rxS;
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      r_stpErr    <= 1'b0;

      if (r_state != IDLE) begin
        r_edgeCnt <= (r_edgeCnt == EDGE_LAST) ? '0 : r_edgeCnt + 1'b1;
        if (r_edgeCnt == EDGE_VOTE0) r_vote0 <= r_rxS;
        if (r_edgeCnt == EDGE_VOTE1) r_vote1 <= r_rxS;
      end

      case (r_state)
        IDLE: begin
          r_edgeCnt <= '0;
          r_bitCnt  <= '0;
          // The detecting cycle itself is sample 0 of the start bit.
          if (w_startEdge) begin
            r_state   <= START;
            r_edgeCnt <= EW'(1);
            r_parEn   <= bus.PAR_EN;
            r_parTyp  <= bus.PAR_TYP;
            r_parBad  <= 1'b0;
          end
        end

        START: begin
          if (r_edgeCnt == EDGE_EVAL && w_maj) begin
            r_state   <= IDLE;
            r_edgeCnt <= '0;
          end else if (r_edgeCnt == EDGE_LAST) begin
            r_state <= DATA;
          end
        end

        DATA: begin
          if (r_edgeCnt == EDGE_EVAL) begin
            r_shift <= {w_maj, r_shift[DW-1:1]};
          end
          if (r_edgeCnt == EDGE_LAST) begin
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
              r_state  <= r_parEn ? PARITY : STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end
        end

        PARITY: begin
          if (r_edgeCnt == EDGE_EVAL) begin
            r_parBad <= (w_maj != w_expPar);
          end
          if (r_edgeCnt == EDGE_LAST) begin
            r_state <= STOP;
          end
        end

        STOP: begin
          // Leave early so a short stop bit still lets the next start edge be seen.
          if (r_edgeCnt == EDGE_EVAL) begin
            r_stpErr  <= ~w_maj;
            r_parErr  <= w_maj & r_parBad;
            r_state   <= IDLE;
            r_edgeCnt <= '0;
            if (w_maj && !r_parBad) begin
              r_pData     <= r_shift;
              r_dataValid <= 1'b1;
            end
          end
        end

        default: begin
          r_state   <= IDLE;
          r_edgeCnt <= '0;
        end
      endcase
    end
  end

  assign bus.P_DATA     = r_pData;
  assign bus.Data_Valid = r_dataValid;
  assign bus.par_err    = r_parErr;
  assign bus.stp_err    = r_stpErr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8: framing, parity, stop errors,
// glitch rejection, back-to-back frames, vote masking and mid-frame reset.
module tb_uart_rx;

  localparam int P = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  uart_rx_if #(.DW(8)) bus ();

  uart_rx #(.PRESCALE(P), .DW(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge away from register updates.
  int dvCount  = 0;
  int parCount = 0;
  int stpCount = 0;
  int lastDv   = 0;
  int prevDv   = 0;
  always @(negedge CLK) begin
    if (bus.Data_Valid === 1'b1) begin
      dvCount++;
      prevDv = lastDv;
      lastDv = cyc;
    end
    if (bus.par_err === 1'b1) parCount++;
    if (bus.stp_err === 1'b1) stpCount++;
  end

  int totalChecks = 0;
  int passCount   = 0;
  int failCount   = 0;
  int startCyc    = 0;
  int firstStart  = 0;
  int d0, p0, s0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic sendBit(input logic b, input bit flip, input int pos);
    for (int i = 0; i < P; i++) begin
      bus.RX_IN = (flip && i == pos) ? ~b : b;
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] data, input bit withPar, input logic parBit,
                               input logic stopBit, input bit flip);
    startCyc = cyc;
    sendBit(1'b0, flip, 3);
    for (int j = 0; j < 8; j++) sendBit(data[j], flip, 3 + ((j + 1) % 3));
    if (withPar) sendBit(parBit, flip, 4);
    sendBit(stopBit, flip, 5);
    bus.RX_IN = 1'b1;
  endtask

  task automatic snap();
    d0 = dvCount;
    p0 = parCount;
    s0 = stpCount;
  endtask

  initial begin
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    RST         = 1'b1;
    idle(4);
    checkOutput("rst_pdata", 32'(bus.P_DATA), 32'h00);
    checkOutput("rst_dv",    32'(bus.Data_Valid), 0);
    checkOutput("rst_par",   32'(bus.par_err), 0);
    checkOutput("rst_stp",   32'(bus.stp_err), 0);
    RST = 1'b0;
    idle(20);

    $display("[TB] frame 0xA5, no parity");
    snap();
    applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("t1_dv_count", 32'(dvCount - d0), 1);
    checkOutput("t1_latency",  32'(lastDv - startCyc), 80);
    checkOutput("t1_pdata",    32'(bus.P_DATA), 32'hA5);
    checkOutput("t1_par",      32'(parCount - p0), 0);
    checkOutput("t1_stp",      32'(stpCount - s0), 0);

    $display("[TB] frame 0x3C, even parity");
    bus.PAR_EN  = 1'b1;
    bus.PAR_TYP = 1'b0;
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("t2_dv_count", 32'(dvCount - d0), 1);
    checkOutput("t2_latency",  32'(lastDv - startCyc), 88);
    checkOutput("t2_pdata",    32'(bus.P_DATA), 32'h3C);
    snap();
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    checkOutput("t2_bad_par",   32'(parCount - p0), 1);
    checkOutput("t2_bad_dv",    32'(dvCount - d0), 0);
    checkOutput("t2_bad_stp",   32'(stpCount - s0), 0);
    checkOutput("t2_bad_pdata", 32'(bus.P_DATA), 32'h3C);
    bus.PAR_TYP = 1'b1;
    snap();
    applyStimulus(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(10);
    checkOutput("t2_odd_dv",    32'(dvCount - d0), 1);
    checkOutput("t2_odd_pdata", 32'(bus.P_DATA), 32'hC3);
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;

    $display("[TB] frame 0x81 with stop bit 0, then 0x55");
    snap();
    applyStimulus(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    checkOutput("t3_stp",   32'(stpCount - s0), 1);
    checkOutput("t3_dv",    32'(dvCount - d0), 0);
    checkOutput("t3_pdata", 32'(bus.P_DATA), 32'hC3);
    snap();
    applyStimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("t3_next_dv",    32'(dvCount - d0), 1);
    checkOutput("t3_next_pdata", 32'(bus.P_DATA), 32'h55);

    $display("[TB] 3-cycle glitch, then 0xF0");
    snap();
    bus.RX_IN = 1'b0;
    idle(3);
    bus.RX_IN = 1'b1;
    idle(40);
    checkOutput("t4_glitch_pulses", 32'((dvCount - d0) + (parCount - p0) + (stpCount - s0)), 0);
    applyStimulus(8'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("t4_dv",      32'(dvCount - d0), 1);
    checkOutput("t4_latency", 32'(lastDv - startCyc), 80);
    checkOutput("t4_pdata",   32'(bus.P_DATA), 32'hF0);

    for (int f = 0; f < 2; f++) begin
      $display("[TB] back-to-back 0x12, 0x34, flipped samples = %0d", f);
      snap();
      applyStimulus(8'h12, 1'b0, 1'b0, 1'b1, f[0]);
      firstStart = startCyc;
      applyStimulus(8'h34, 1'b0, 1'b0, 1'b1, f[0]);
      idle(10);
      checkOutput("t5_dv_count", 32'(dvCount - d0), 2);
      checkOutput("t5_first",    32'(prevDv - firstStart), 80);
      checkOutput("t5_spacing",  32'(lastDv - prevDv), 80);
      checkOutput("t5_pdata",    32'(bus.P_DATA), 32'h34);
      checkOutput("t5_errs",     32'((parCount - p0) + (stpCount - s0)), 0);
    end

    $display("[TB] reset during data bit 4 of 0xFF, then 0x0F");
    snap();
    sendBit(1'b0, 1'b0, 0);
    for (int j = 0; j < 4; j++) sendBit(1'b1, 1'b0, 0);
    bus.RX_IN = 1'b1;
    idle(3);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    checkOutput("t6_rst_pdata", 32'(bus.P_DATA), 32'h00);
    checkOutput("t6_rst_dv",    32'(bus.Data_Valid), 0);
    idle(60);
    checkOutput("t6_no_pulses", 32'((dvCount - d0) + (parCount - p0) + (stpCount - s0)), 0);
    checkOutput("t6_hold",      32'(bus.P_DATA), 32'h00);
    applyStimulus(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(10);
    checkOutput("t6_dv",      32'(dvCount - d0), 1);
    checkOutput("t6_latency", 32'(lastDv - startCyc), 80);
    checkOutput("t6_pdata",   32'(bus.P_DATA), 32'h0F);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
